tlul_socket_1n: RTL and testbench

- 1:N TL-UL demultiplexer: one host port fans out to N device ports. Counterpart of the M:1 socket in the crossbar.
- Steers each A-channel request to the device chosen by an external address decoder (dev_select_i), and steers the D-channel response back to the host.
- Tracks outstanding transactions so responses return in order from a single device.
- Unmapped selects are answered by an internal error responder.

---
 rtl/tlul_pkg.sv | 59 +++++
 rtl/tlul_err_resp.sv | 80 ++++++++
 rtl/tlul_socket_1n.sv | 98 +++++++++
 tb/tb_tlul_socket_1n.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// TL-UL channel types, opcodes and shared constants for the socket and its
// error responder.
package tlul_pkg;

    localparam int TL_DW  = 32;
    localparam int TL_AW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    localparam logic [TL_DW-1:0] ErrRespData = {TL_DW{1'b1}};

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // Reads return data; both put flavours only acknowledge.
    function automatic tl_d_op_e resp_opcode(input tl_a_op_e op);
        tl_d_op_e r;
        case (op)
            Get:     r = AccessAckData;
            default: r = AccessAck;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tlul_err_resp.sv
// Single-outstanding TL-UL error responder: acknowledges any request with
// d_error set and all-ones data, one cycle after acceptance.
module tlul_err_resp
    import tlul_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o
);

    typedef enum logic [0:0] {
        ErrIdle = 1'b0,
        ErrResp = 1'b1
    } err_state_e;

    err_state_e         state_q, state_d;
    logic [TL_AIW-1:0]  source_q, source_d;
    logic [TL_SZW-1:0]  size_q, size_d;
    tl_d_op_e           op_q, op_d;
    logic               unused_s;

    assign unused_s = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask, tl_h_i.a_data};

    // Next-state and capture logic; a_valid is already gated by the socket.
    always_comb begin
        state_d  = state_q;
        source_d = source_q;
        size_d   = size_q;
        op_d     = op_q;
        case (state_q)
            ErrIdle: begin
                if (tl_h_i.a_valid) begin
                    state_d  = ErrResp;
                    source_d = tl_h_i.a_source;
                    size_d   = tl_h_i.a_size;
                    op_d     = resp_opcode(tl_h_i.a_opcode);
                end else begin
                    state_d  = ErrIdle;
                end
            end
            ErrResp: begin
                if (tl_h_i.d_ready) begin
                    state_d = ErrIdle;
                end else begin
                    state_d = ErrResp;
                end
            end
            default: state_d = ErrIdle;
        endcase
    end

    // State and captured request fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ErrIdle;
            source_q <= {TL_AIW{1'b0}};
            size_q   <= {TL_SZW{1'b0}};
            op_q     <= AccessAck;
        end else begin
            state_q  <= state_d;
            source_q <= source_d;
            size_q   <= size_d;
            op_q     <= op_d;
        end
    end

    // Response fields are decoded straight from flops, so they hold until d_ready.
    always_comb begin
        tl_h_o          = '0;
        tl_h_o.a_ready  = (state_q == ErrIdle);
        tl_h_o.d_valid  = (state_q == ErrResp);
        tl_h_o.d_error  = (state_q == ErrResp);
        tl_h_o.d_opcode = op_q;
        tl_h_o.d_size   = size_q;
        tl_h_o.d_source = source_q;
        tl_h_o.d_data   = ErrRespData;
    end

endmodule

// File: rtl/tlul_socket_1n.sv
// 1:N TL-UL demultiplexer: steers host requests to one of N devices and
// returns responses in order; unmapped selects go to an error responder.
module tlul_socket_1n
    import tlul_pkg::*;
#(
    parameter  int N              = 4,
    parameter  int MaxOutstanding = 8,
    localparam int NWD            = $clog2(N + 1),
    localparam int CW             = $clog2(MaxOutstanding + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  tl_h2d_t        tl_h_i,
    output tl_d2h_t        tl_h_o,
    output tl_h2d_t        tl_d_o [N],
    input  tl_d2h_t        tl_d_i [N],
    input  logic [NWD-1:0] dev_select_i
);

    logic [CW-1:0]  num_out_q, num_out_d;
    logic [NWD-1:0] dev_out_q, dev_out_d;
    logic [NWD-1:0] sel_s;
    logic           hold_s;
    logic           accept_s;
    logic           complete_s;
    tl_h2d_t        err_req_s;
    tl_d2h_t        err_rsp_s;
    tl_d2h_t        rsp_s [N+1];

    // Target selection; a full counter holds even if a response retires now.
    always_comb begin
        sel_s  = (dev_select_i >= NWD'(N)) ? NWD'(N) : dev_select_i;
        hold_s = ((num_out_q != {CW{1'b0}}) && (sel_s != dev_out_q)) ||
                 (num_out_q == CW'(MaxOutstanding));
    end

    // Request fan-out; only valid and d_ready are steered, the rest is broadcast.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid & ~hold_s & (sel_s == NWD'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready & (dev_out_q == NWD'(i));
        end
        err_req_s         = tl_h_i;
        err_req_s.a_valid = tl_h_i.a_valid & ~hold_s & (sel_s == NWD'(N));
        err_req_s.d_ready = tl_h_i.d_ready & (dev_out_q == NWD'(N));
    end

    tlul_err_resp u_err_resp (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tl_h_i (err_req_s),
        .tl_h_o (err_rsp_s)
    );

    // Device responses and the error responder form one table indexed by target.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rsp_s[i] = tl_d_i[i];
        end
        rsp_s[N] = err_rsp_s;
    end

    // Response return; stray d_valid with nothing outstanding is suppressed.
    always_comb begin
        tl_h_o         = rsp_s[dev_out_q];
        tl_h_o.d_valid = rsp_s[dev_out_q].d_valid & (num_out_q != {CW{1'b0}});
        tl_h_o.a_ready = ~hold_s & rsp_s[sel_s].a_ready;
    end

    // Outstanding tracking: simultaneous accept and complete cancel out.
    always_comb begin
        accept_s   = tl_h_i.a_valid & tl_h_o.a_ready;
        complete_s = tl_h_o.d_valid & tl_h_i.d_ready;
        if (accept_s) begin
            dev_out_d = sel_s;
        end else begin
            dev_out_d = dev_out_q;
        end
        case ({accept_s, complete_s})
            2'b10:   num_out_d = num_out_q + CW'(1);
            2'b01:   num_out_d = num_out_q - CW'(1);
            default: num_out_d = num_out_q;
        endcase
    end

    // Counter and target registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_out_q <= {CW{1'b0}};
            dev_out_q <= {NWD{1'b0}};
        end else begin
            num_out_q <= num_out_d;
            dev_out_q <= dev_out_d;
        end
    end

endmodule

// File: tb/tb_tlul_socket_1n.sv
// Directed bench for tlul_socket_1n with N=4, MaxOutstanding=2.
module tb_tlul_socket_1n;
    import tlul_pkg::*;

    logic       clk;
    logic       rst_n;
    tl_h2d_t    tl_h_i;
    tl_d2h_t    tl_h_o;
    tl_h2d_t    tl_d_o [4];
    tl_d2h_t    tl_d_i [4];
    logic [2:0] dev_sel;
    int         passed;
    int         total;

    tlul_socket_1n #(.N(4), .MaxOutstanding(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tl_h_i       (tl_h_i),
        .tl_h_o       (tl_h_o),
        .tl_d_o       (tl_d_o),
        .tl_d_i       (tl_d_i),
        .dev_select_i (dev_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tl_h_i         = '0;
        tl_h_i.d_ready = 1'b1;
        dev_sel        = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tl_d_i[i]         = '0;
            tl_d_i[i].a_ready = 1'b1;
        end
    endtask

    task automatic host_req(input tl_a_op_e op, input logic [7:0] src, input logic [1:0] sz, input logic [2:0] sel);
        tl_h_i.a_valid  = 1'b1;
        tl_h_i.a_opcode = op;
        tl_h_i.a_source = src;
        tl_h_i.a_size   = sz;
        tl_h_i.a_address = 32'h0000_1000;
        tl_h_i.a_mask   = 4'hF;
        tl_h_i.a_data   = 32'hA5A5_0000;
        dev_sel         = sel;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #12;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL rst_num_out: got %0d expected 0", dut.num_out_q); else passed++;
        total++; if (dut.dev_out_q !== 3'd0) $display("FAIL rst_dev_out: got %0d expected 0", dut.dev_out_q); else passed++;
        total++; if (tl_h_o.d_valid !== 1'b0) $display("FAIL rst_d_valid: got %b expected 0", tl_h_o.d_valid); else passed++;
        rst_n = 1'b1;
        tick();
        tl_d_i[0].d_valid = 1'b1;
        #1;
        total++; if (tl_h_o.d_valid !== 1'b0) $display("FAIL stray_d_valid: got %b expected 0", tl_h_o.d_valid); else passed++;
        tl_d_i[0].d_valid = 1'b0;
    endtask

    task automatic test_basic_get();
        host_req(Get, 8'h03, 2'd2, 3'd2);
        #1;
        total++; if (tl_d_o[2].a_valid !== 1'b1) $display("FAIL t1_dev2_a_valid: got %b expected 1", tl_d_o[2].a_valid); else passed++;
        total++; if ({tl_d_o[0].a_valid, tl_d_o[1].a_valid, tl_d_o[3].a_valid} !== 3'b000) $display("FAIL t1_other_a_valid: got %b%b%b expected 000", tl_d_o[0].a_valid, tl_d_o[1].a_valid, tl_d_o[3].a_valid); else passed++;
        total++; if (tl_h_o.a_ready !== 1'b1) $display("FAIL t1_a_ready: got %b expected 1", tl_h_o.a_ready); else passed++;
        total++; if (tl_d_o[2].a_source !== 8'h03) $display("FAIL t1_src_bcast: got %h expected 03", tl_d_o[2].a_source); else passed++;
        tick();
        tl_h_i.a_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd1) $display("FAIL t1_num_out1: got %0d expected 1", dut.num_out_q); else passed++;
        tl_d_i[2].d_valid  = 1'b1;
        tl_d_i[2].d_opcode = AccessAckData;
        tl_d_i[2].d_source = 8'h03;
        tl_d_i[2].d_data   = 32'hDEAD_BEEF;
        #1;
        total++; if (tl_h_o.d_valid !== 1'b1) $display("FAIL t1_d_valid: got %b expected 1", tl_h_o.d_valid); else passed++;
        total++; if (tl_h_o.d_data !== 32'hDEAD_BEEF) $display("FAIL t1_d_data: got %h expected deadbeef", tl_h_o.d_data); else passed++;
        total++; if (tl_d_o[2].d_ready !== 1'b1) $display("FAIL t1_dev2_d_ready: got %b expected 1", tl_d_o[2].d_ready); else passed++;
        tick();
        tl_d_i[2].d_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL t1_num_out0: got %0d expected 0", dut.num_out_q); else passed++;
    endtask

    task automatic test_switch_hold();
        host_req(PutFullData, 8'h01, 2'd2, 3'd1);
        tick();
        host_req(Get, 8'h02, 2'd2, 3'd3);
        tl_d_i[1].d_opcode = AccessAck;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (tl_h_o.a_ready !== 1'b0) $display("FAIL t2_held_a_ready c%0d: got %b expected 0", c, tl_h_o.a_ready); else passed++;
            total++; if (tl_d_o[3].a_valid !== 1'b0) $display("FAIL t2_held_dev3 c%0d: got %b expected 0", c, tl_d_o[3].a_valid); else passed++;
            tick();
        end
        tl_d_i[1].d_valid = 1'b1;
        #1;
        total++; if (tl_h_o.a_ready !== 1'b0) $display("FAIL t2_rsp_a_ready: got %b expected 0", tl_h_o.a_ready); else passed++;
        total++; if (tl_h_o.d_valid !== 1'b1) $display("FAIL t2_rsp_d_valid: got %b expected 1", tl_h_o.d_valid); else passed++;
        tick();
        tl_d_i[1].d_valid = 1'b0;
        #1;
        total++; if (tl_h_o.a_ready !== 1'b1) $display("FAIL t2_fwd_a_ready: got %b expected 1", tl_h_o.a_ready); else passed++;
        total++; if (tl_d_o[3].a_valid !== 1'b1) $display("FAIL t2_fwd_dev3: got %b expected 1", tl_d_o[3].a_valid); else passed++;
        tick();
        tl_h_i.a_valid = 1'b0;
        total++; if (dut.dev_out_q !== 3'd3) $display("FAIL t2_dev_out: got %0d expected 3", dut.dev_out_q); else passed++;
        tl_d_i[3].d_valid = 1'b1;
        tick();
        tl_d_i[3].d_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL t2_drain: got %0d expected 0", dut.num_out_q); else passed++;
    endtask

    task automatic test_full();
        host_req(Get, 8'h10, 2'd2, 3'd0);
        tick();
        tick();
        #1;
        total++; if (dut.num_out_q !== 2'd2) $display("FAIL t3_num_out2: got %0d expected 2", dut.num_out_q); else passed++;
        total++; if (tl_h_o.a_ready !== 1'b0) $display("FAIL t3_full_a_ready: got %b expected 0", tl_h_o.a_ready); else passed++;
        tl_d_i[0].d_valid = 1'b1;
        #1;
        total++; if (tl_h_o.a_ready !== 1'b0) $display("FAIL t3_full_nobypass: got %b expected 0", tl_h_o.a_ready); else passed++;
        total++; if (tl_d_o[0].a_valid !== 1'b0) $display("FAIL t3_full_dev0_a_valid: got %b expected 0", tl_d_o[0].a_valid); else passed++;
        tick();
        tl_d_i[0].d_valid = 1'b0;
        #1;
        total++; if (dut.num_out_q !== 2'd1) $display("FAIL t3_num_out1: got %0d expected 1", dut.num_out_q); else passed++;
        total++; if (tl_h_o.a_ready !== 1'b1) $display("FAIL t3_reopen_a_ready: got %b expected 1", tl_h_o.a_ready); else passed++;
        tick();
        tl_h_i.a_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd2) $display("FAIL t3_third_accept: got %0d expected 2", dut.num_out_q); else passed++;
        tl_d_i[0].d_valid = 1'b1;
        tick();
        tick();
        tl_d_i[0].d_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL t3_drain: got %0d expected 0", dut.num_out_q); else passed++;
    endtask

    task automatic test_err_resp();
        host_req(Get, 8'h05, 2'd2, 3'd4);
        #1;
        total++; if (tl_h_o.a_ready !== 1'b1) $display("FAIL t4_a_ready: got %b expected 1", tl_h_o.a_ready); else passed++;
        total++; if ({tl_d_o[0].a_valid, tl_d_o[1].a_valid, tl_d_o[2].a_valid, tl_d_o[3].a_valid} !== 4'b0000) $display("FAIL t4_no_dev_a_valid: got %b%b%b%b expected 0000", tl_d_o[0].a_valid, tl_d_o[1].a_valid, tl_d_o[2].a_valid, tl_d_o[3].a_valid); else passed++;
        tick();
        tl_h_i.d_ready = 1'b0;
        host_req(Get, 8'h06, 2'd1, 3'd7);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (tl_h_o.d_valid !== 1'b1) $display("FAIL t4_d_valid c%0d: got %b expected 1", c, tl_h_o.d_valid); else passed++;
            total++; if (tl_h_o.d_error !== 1'b1) $display("FAIL t4_d_error c%0d: got %b expected 1", c, tl_h_o.d_error); else passed++;
            total++; if (tl_h_o.d_opcode !== AccessAckData) $display("FAIL t4_d_opcode c%0d: got %0d expected 1", c, tl_h_o.d_opcode); else passed++;
            total++; if (tl_h_o.d_source !== 8'h05) $display("FAIL t4_d_source c%0d: got %h expected 05", c, tl_h_o.d_source); else passed++;
            total++; if (tl_h_o.d_size !== 2'd2) $display("FAIL t4_d_size c%0d: got %0d expected 2", c, tl_h_o.d_size); else passed++;
            total++; if (tl_h_o.d_data !== 32'hFFFF_FFFF) $display("FAIL t4_d_data c%0d: got %h expected ffffffff", c, tl_h_o.d_data); else passed++;
            total++; if (tl_h_o.a_ready !== 1'b0) $display("FAIL t4_second_a_ready c%0d: got %b expected 0", c, tl_h_o.a_ready); else passed++;
            tick();
        end
        tl_h_i.a_valid = 1'b0;
        tl_h_i.d_ready = 1'b1;
        tick();
        #1;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL t4_num_out0: got %0d expected 0", dut.num_out_q); else passed++;
        total++; if (tl_h_o.d_valid !== 1'b0) $display("FAIL t4_d_valid_end: got %b expected 0", tl_h_o.d_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        host_req(Get, 8'h20, 2'd2, 3'd0);
        tick();
        tl_d_i[0].d_valid = 1'b1;
        #1;
        total++; if (tl_h_o.a_ready !== 1'b1) $display("FAIL t5_a_ready: got %b expected 1", tl_h_o.a_ready); else passed++;
        total++; if (tl_h_o.d_valid !== 1'b1) $display("FAIL t5_d_valid: got %b expected 1", tl_h_o.d_valid); else passed++;
        tick();
        tl_h_i.a_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd1) $display("FAIL t5_num_out: got %0d expected 1", dut.num_out_q); else passed++;
        total++; if (dut.dev_out_q !== 3'd0) $display("FAIL t5_dev_out: got %0d expected 0", dut.dev_out_q); else passed++;
        tick();
        tl_d_i[0].d_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL t5_drain: got %0d expected 0", dut.num_out_q); else passed++;
    endtask

    task automatic test_async_reset();
        host_req(Get, 8'h30, 2'd2, 3'd1);
        tick();
        tick();
        tl_h_i.a_valid = 1'b0;
        tl_h_i.d_ready = 1'b0;
        tl_d_i[1].d_valid = 1'b1;
        #1;
        total++; if (tl_h_o.d_valid !== 1'b1) $display("FAIL t6_pre_d_valid: got %b expected 1", tl_h_o.d_valid); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (tl_h_o.d_valid !== 1'b0) $display("FAIL t6_async_d_valid: got %b expected 0", tl_h_o.d_valid); else passed++;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL t6_async_num_out: got %0d expected 0", dut.num_out_q); else passed++;
        total++; if (dut.dev_out_q !== 3'd0) $display("FAIL t6_async_dev_out: got %0d expected 0", dut.dev_out_q); else passed++;
        tl_d_i[1].d_valid = 1'b0;
        tl_h_i.d_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        host_req(Get, 8'h31, 2'd2, 3'd3);
        #1;
        total++; if (tl_d_o[3].a_valid !== 1'b1) $display("FAIL t6_post_dev3: got %b expected 1", tl_d_o[3].a_valid); else passed++;
        total++; if (tl_h_o.a_ready !== 1'b1) $display("FAIL t6_post_a_ready: got %b expected 1", tl_h_o.a_ready); else passed++;
        tick();
        tl_h_i.a_valid = 1'b0;
        tl_d_i[3].d_valid = 1'b1;
        tl_d_i[3].d_data  = 32'h1234_5678;
        #1;
        total++; if (tl_h_o.d_data !== 32'h1234_5678) $display("FAIL t6_post_d_data: got %h expected 12345678", tl_h_o.d_data); else passed++;
        tick();
        tl_d_i[3].d_valid = 1'b0;
        total++; if (dut.num_out_q !== 2'd0) $display("FAIL t6_post_drain: got %0d expected 0", dut.num_out_q); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_basic_get();
        test_switch_hold();
        test_full();
        test_err_resp();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
